// File: rtl/rom_pkg.sv
// Shared types and the 7-segment table for the burst-reading ROM.
// seg_word() maps any index onto the 16-entry table at any word width.
package rom_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  // gfedcba, active-high, for hex digits 0..F
  localparam logic [6:0] SEG_TABLE [0:15] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [31:0] seg_word(
    input int unsigned index,
    input int unsigned data_w
  );
    logic [31:0] w;
    w = {25'd0, SEG_TABLE[index[3:0]]};
    if (data_w < 32)
      w = w & ((32'd1 << data_w) - 32'd1);
    return w;
  endfunction

endpackage

// File: rtl/rom_core.sv
// Synchronous segment ROM: one-cycle registered read gated by re_i.
// Addresses at or beyond DEPTH read as zero.
module rom_core
  import rom_pkg::*;
#(
  parameter int DATA_W = 7,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] word;
  logic [DATA_W-1:0] data_q;

  always_comb begin
    word = '0;
    if (32'(addr_i) < DEPTH)
      word = DATA_W'(seg_word(32'(addr_i), DATA_W));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      data_q <= '0;
    else if (re_i)
      data_q <= word;
  end

  assign data_o = data_q;

endmodule

// File: rtl/rom_burst_reader.sv
// Segment ROM with manual reads and wrap-around burst sequencing.
// Address echo, valid and done are registered alongside the ROM word.
module rom_burst_reader
  import rom_pkg::*;
#(
  parameter int DATA_W = 7,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              mode,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LEN_W-1:0]  burst_len,
  output logic [DATA_W-1:0] data_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic              valid,
  output logic              busy,
  output logic              done
);

  state_e state_q, state_d;
  logic [ADDR_W-1:0] cursor_q, cursor_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [ADDR_W-1:0] addr_out_q, addr_out_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] cursor_nx;
  logic              go;

  assign base = ADDR_W'(32'(addr) % DEPTH);
  assign go   = start && mode && (burst_len != '0);

  assign cursor_nx =
    (cursor_q == ADDR_W'(DEPTH - 1)) ? '0
                                     : cursor_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    cursor_d   = cursor_q;
    rem_d      = rem_q;
    addr_out_d = addr_out_q;
    valid_d    = 1'b0;
    done_d     = 1'b0;
    rd_en      = 1'b0;
    rd_addr    = addr;
    unique case (state_q)
      IDLE: begin
        if (ena) begin
          if (go) begin
            state_d  = BURST;
            cursor_d = base;
            rem_d    = burst_len;
          end else begin
            rd_en      = 1'b1;
            rd_addr    = addr;
            addr_out_d = addr;
            valid_d    = 1'b1;
          end
        end
      end
      BURST: begin
        if (ena) begin
          rd_en      = 1'b1;
          rd_addr    = cursor_q;
          addr_out_d = cursor_q;
          valid_d    = 1'b1;
          cursor_d   = cursor_nx;
          rem_d      = rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cursor_q   <= '0;
      rem_q      <= '0;
      addr_out_q <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cursor_q   <= cursor_d;
      rem_q      <= rem_d;
      addr_out_q <= addr_out_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
    end
  end

  rom_core #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_rom (
    .clk   (clk),
    .rst   (rst),
    .re_i  (rd_en),
    .addr_i(rd_addr),
    .data_o(data_out)
  );

  assign addr_out = addr_out_q;
  assign valid    = valid_q;
  assign busy     = (state_q == BURST);
  assign done     = done_q;

endmodule

// File: tb/tb_rom_burst_reader.sv
// Directed bench for rom_burst_reader: manual, hold, burst, pause,
// reset abort, short-depth and back-to-back scenarios.
module tb_rom_burst_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b0;
  logic       mode = 1'b0;
  logic       start = 1'b0;
  logic [3:0] addr = '0;
  logic [3:0] burst_len = '0;

  logic [6:0] data_out, data_out10;
  logic [3:0] addr_out, addr_out10;
  logic       valid, valid10;
  logic       busy, busy10;
  logic       done, done10;

  int checks = 0;
  int errors = 0;

  logic [6:0] seg [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  always #5 clk = ~clk;

  rom_burst_reader #(
    .DATA_W(7), .ADDR_W(4), .DEPTH(16), .LEN_W(4)
  ) u_dut (
    .clk(clk), .rst(rst), .ena(ena), .mode(mode),
    .start(start), .addr(addr), .burst_len(burst_len),
    .data_out(data_out), .addr_out(addr_out),
    .valid(valid), .busy(busy), .done(done)
  );

  rom_burst_reader #(
    .DATA_W(7), .ADDR_W(4), .DEPTH(10), .LEN_W(4)
  ) u_dut10 (
    .clk(clk), .rst(rst), .ena(ena), .mode(mode),
    .start(start), .addr(addr), .burst_len(burst_len),
    .data_out(data_out10), .addr_out(addr_out10),
    .valid(valid10), .busy(busy10), .done(done10)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++;
    if ({data_out, addr_out, valid, busy, done} !== 14'd0) begin
      errors++;
      $display("FAIL reset got d=%h a=%h v=%b b=%b dn=%b want all 0",
               data_out, addr_out, valid, busy, done);
    end
    checks++;
    if ({data_out10, addr_out10, valid10, busy10, done10} !== 14'd0) begin
      errors++;
      $display("FAIL reset10 got d=%h a=%h v=%b want all 0",
               data_out10, addr_out10, valid10);
    end
    rst = 1'b0;
  endtask

  task automatic test_manual();
    ena = 1'b1; mode = 1'b0; start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      addr = 4'(i);
      tick();
      checks++;
      if (data_out !== seg[i] || addr_out !== 4'(i) || valid !== 1'b1) begin
        errors++;
        $display("FAIL manual[%0d] got d=%h a=%0d v=%b want d=%h a=%0d v=1",
                 i, data_out, addr_out, valid, seg[i], i);
      end
    end
  endtask

  task automatic test_hold();
    ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      addr = 4'(i);
      tick();
      checks++;
      if (data_out !== 7'h71 || addr_out !== 4'd15 || valid !== 1'b0) begin
        errors++;
        $display("FAIL hold[%0d] got d=%h a=%0d v=%b want d=71 a=15 v=0",
                 i, data_out, addr_out, valid);
      end
    end
  endtask

  task automatic test_burst_wrap();
    logic [3:0] ea [4] = '{4'd14, 4'd15, 4'd0, 4'd1};
    logic [6:0] ed [4] = '{7'h79, 7'h71, 7'h3F, 7'h06};
    ena = 1'b1; mode = 1'b1; start = 1'b1;
    addr = 4'd14; burst_len = 4'd4;
    tick();
    start = 1'b0;
    checks++;
    if (valid !== 1'b0 || busy !== 1'b1 || data_out !== 7'h71 ||
        addr_out !== 4'd15) begin
      errors++;
      $display("FAIL wrap_accept got v=%b b=%b d=%h a=%0d want v=0 b=1 d=71 a=15",
               valid, busy, data_out, addr_out);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (addr_out !== ea[i] || data_out !== ed[i] || valid !== 1'b1 ||
          done !== (i == 3) || busy !== (i != 3)) begin
        errors++;
        $display("FAIL wrap_beat[%0d] got a=%0d d=%h v=%b dn=%b b=%b want a=%0d d=%h",
                 i, addr_out, data_out, valid, done, busy, ea[i], ed[i]);
      end
    end
  endtask

  task automatic test_pause();
    ena = 1'b1; mode = 1'b1; start = 1'b1;
    addr = 4'd2; burst_len = 4'd5;
    tick();
    start = 1'b0;
    for (int i = 2; i < 4; i++) begin
      tick();
      checks++;
      if (addr_out !== 4'(i) || data_out !== seg[i] || valid !== 1'b1 ||
          done !== 1'b0) begin
        errors++;
        $display("FAIL pause_pre[%0d] got a=%0d d=%h v=%b dn=%b",
                 i, addr_out, data_out, valid, done);
      end
    end
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (valid !== 1'b0 || done !== 1'b0 || busy !== 1'b1 ||
          addr_out !== 4'd3 || data_out !== 7'h4F) begin
        errors++;
        $display("FAIL pause_hold[%0d] got v=%b dn=%b b=%b a=%0d d=%h",
                 i, valid, done, busy, addr_out, data_out);
      end
    end
    ena = 1'b1;
    for (int i = 4; i < 7; i++) begin
      tick();
      checks++;
      if (addr_out !== 4'(i) || data_out !== seg[i] || valid !== 1'b1 ||
          done !== (i == 6) || busy !== (i != 6)) begin
        errors++;
        $display("FAIL pause_post[%0d] got a=%0d d=%h v=%b dn=%b b=%b",
                 i, addr_out, data_out, valid, done, busy);
      end
    end
  endtask

  task automatic test_reset_mid();
    ena = 1'b1; mode = 1'b1; start = 1'b1;
    addr = 4'd0; burst_len = 4'd8;
    tick();
    start = 1'b0;
    tick();
    tick();
    checks++;
    if (addr_out !== 4'd1 || data_out !== 7'h06 || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre got a=%0d d=%h b=%b want a=1 d=06 b=1",
               addr_out, data_out, busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({data_out, addr_out, valid, busy, done} !== 14'd0) begin
      errors++;
      $display("FAIL abort_async got d=%h a=%0d v=%b b=%b dn=%b want all 0",
               data_out, addr_out, valid, busy, done);
    end
    tick();
    #2;
    rst = 1'b0;
    mode = 1'b0; addr = 4'd9;
    tick();
    checks++;
    if (data_out !== 7'h6F || addr_out !== 4'd9 || valid !== 1'b1 ||
        done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_after got d=%h a=%0d v=%b dn=%b b=%b want d=6F a=9 v=1",
               data_out, addr_out, valid, done, busy);
    end
  endtask

  task automatic test_depth10();
    ena = 1'b1; mode = 1'b0; start = 1'b0;
    addr = 4'd12;
    tick();
    checks++;
    if (data_out10 !== 7'h00 || addr_out10 !== 4'd12 || valid10 !== 1'b1) begin
      errors++;
      $display("FAIL depth10_oob got d=%h a=%0d v=%b want d=00 a=12 v=1",
               data_out10, addr_out10, valid10);
    end
    checks++;
    if (data_out !== 7'h39) begin
      errors++;
      $display("FAIL depth16_c got d=%h want 39", data_out);
    end
    addr = 4'd9;
    tick();
    checks++;
    if (data_out10 !== 7'h6F || valid10 !== 1'b1) begin
      errors++;
      $display("FAIL depth10_last got d=%h v=%b want d=6F v=1",
               data_out10, valid10);
    end
  endtask

  task automatic test_len0();
    ena = 1'b1; mode = 1'b1; start = 1'b1;
    addr = 4'd5; burst_len = 4'd0;
    tick();
    checks++;
    if (data_out !== 7'h6D || addr_out !== 4'd5 || valid !== 1'b1 ||
        busy !== 1'b0) begin
      errors++;
      $display("FAIL len0 got d=%h a=%0d v=%b b=%b want d=6D a=5 v=1 b=0",
               data_out, addr_out, valid, busy);
    end
    start = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] ea [3] = '{4'd0, 4'd1, 4'd2};
    ena = 1'b1; mode = 1'b1; start = 1'b1;
    addr = 4'd0; burst_len = 4'd3;
    tick();
    addr = 4'd8; burst_len = 4'd2;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (addr_out !== ea[i] || data_out !== seg[i] || valid !== 1'b1 ||
          done !== (i == 2) || busy !== (i != 2)) begin
        errors++;
        $display("FAIL b2b_first[%0d] got a=%0d d=%h v=%b dn=%b b=%b",
                 i, addr_out, data_out, valid, done, busy);
      end
    end
    tick();
    start = 1'b0;
    checks++;
    if (valid !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept got v=%b b=%b dn=%b want v=0 b=1 dn=0",
               valid, busy, done);
    end
    for (int i = 8; i < 10; i++) begin
      tick();
      checks++;
      if (addr_out !== 4'(i) || data_out !== seg[i] || valid !== 1'b1 ||
          done !== (i == 9)) begin
        errors++;
        $display("FAIL b2b_second[%0d] got a=%0d d=%h v=%b dn=%b",
                 i, addr_out, data_out, valid, done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_hold();
    test_burst_wrap();
    test_pause();
    test_reset_mid();
    test_depth10();
    test_len0();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rom_burst_reader.md
Name: rom_burst_reader

Overview:
Parametrised synchronous ROM with a built-in address sequencer; next generation of the 4-bit-address, 7-bit-data segment ROM. Supports two modes. In manual mode, the user supplies each address. In burst mode, a single start request makes the block read N consecutive words with wrap-around. Sits between memory-test/control logic and display/consumer logic; gives a registered data, address echo and valid/done status.

Parameters:
DATA_W, 7, output word width; table entries zero-extended if DATA_W>7, truncated to LSBs if <7
ADDR_W, 4, address width
DEPTH, 16, number of ROM words (2 ≤ DEPTH ≤ 2**ADDR_W)
LEN_W, 4, width of burst_len

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
ena  in  1  global enable; 0 pauses all reads and sequencing
mode  in  1  0 = manual, 1 = burst (sampled only when a start is accepted)
start  in  1  burst request, level-sampled in IDLE
addr  in  ADDR_W  manual read address / burst base address
burst_len  in  LEN_W  number of words in the burst
data_out  out  DATA_W  registered ROM word
addr_out  out  ADDR_W  address that produced data_out
valid  out  1  data_out/addr_out updated this cycle
busy  out  1  high while in BURST state
done  out  1  one-cycle pulse with the last burst beat

Behaviour:
- Contents: entry i = 7-segment code (bit order gfedcba, active-high) of hex digit (i mod 16).
  - Codes 0..F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
- Reset (async, any time, including mid-burst):
  - data_out=0, addr_out=0, valid=0, busy=0, done=0, state=IDLE, cursor=0, remaining=0.
  - An aborted burst never produces done.
- States: IDLE, BURST.
- IDLE, ena=0: data_out/addr_out hold; valid=0; start ignored.
- IDLE, ena=1, and not (start=1 with mode=1): manual read.
  - Next edge: data_out=rom[addr], addr_out=addr, valid=1. Latency 1 cycle.
  - addr ≥ DEPTH: data_out=0, addr_out=addr, valid=1.
- IDLE, ena=1, start=1, mode=1, burst_len≠0: start accepted at that edge.
  - cursor = addr mod DEPTH, remaining = burst_len, state=BURST, busy=1.
  - No read on that edge: valid=0, outputs hold.
- IDLE, start=1, mode=1, burst_len=0: start ignored; the cycle behaves as a manual read.
- BURST, ena=1, each edge:
  - data_out=rom[cursor], addr_out=cursor, valid=1.
  - cursor = (cursor==DEPTH-1) ? 0 : cursor+1; remaining decrements.
  - On the beat where remaining==1: done=1, state=IDLE, busy=0 at the same edge.
- BURST, ena=0: cursor/remaining/outputs hold; valid=0, done=0; burst resumes when ena returns.
- In BURST, start, mode, addr and burst_len are ignored.
- Timing: first burst beat is valid 2 edges after start is sampled; N beats take N enabled cycles.
- A start presented in the cycle after done is accepted normally (back-to-back bursts, one idle edge between them).
- done and valid are registered; done is never high without valid.

Decomposition:
- Package rom_pkg: SEG_TABLE[0:15] constant, state enum (IDLE=0, BURST=1), function seg_word(index, DATA_W) that applies mod-16 indexing and zero-extend/truncate.
- Sub-module rom_core: DEPTH×DATA_W synchronous ROM with a read-enable, 1-cycle registered read, and out-of-range → 0.
- rom_burst_reader holds the FSM, cursor/remaining counters and status registers.

Test Plan:
- Reset then manual mode, ena=1, addr 0..15 one per cycle -> data_out follows 3F,06,5B,…,71 one cycle later; addr_out echoes addr; valid=1 each cycle.
- Manual, ena=0 with addr stepping 0..4 -> data_out/addr_out frozen at last values; valid=0.
- Burst with addr=14, burst_len=4 -> beats at addr_out 14,15,0,1 with data 79,71,3F,06; busy high for the burst; done=1 only with addr_out=1.
- Burst addr=2, len=5; drop ena for 3 cycles after the 2nd beat -> beats 2,3 then pause (valid=0, outputs hold), then 4,5,6; done with 6.
- Assert rst mid-burst (after beat 2 of len 8) -> all outputs 0 immediately; no done; next manual read addr=9 gives 6F.
- Edge cases:
  - DEPTH=10 with manual addr=12 -> data_out=0, valid=1.
  - start with burst_len=0 -> behaves as a manual read; busy stays 0.
  - start during BURST -> ignored.
